// File: rtl/clock_set_controller_pkg.sv
// ============================================================================
// Module      : clock_set_controller_pkg
// Description : Shared states, field indices and default limits for the
//               wall-clock time-setting sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_set_controller_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SNAP    = 3'd1,
        EDIT_L2 = 3'd2,
        EDIT_L1 = 3'd3,
        EDIT_L0 = 3'd4,
        COMMIT  = 3'd5
    } set_state_t;

    localparam int F_L0 = 0;
    localparam int F_L1 = 1;
    localparam int F_L2 = 2;

    localparam int DEF_L0_LIMIT     = 60;
    localparam int DEF_L1_LIMIT     = 60;
    localparam int DEF_L2_LIMIT     = 24;
    localparam int DEF_LOAD_CYCLES  = 1;
    localparam int DEF_BLINK_HALF   = 250000;
    localparam int DEF_IDLE_TIMEOUT = 10000000;

    // Out-of-range live values (e.g. during core power-up) start editing at 0.
    function automatic logic [5:0] snap_field(input logic [5:0] value, input int limit);
        return (int'(value) >= limit) ? 6'd0 : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_set_controller_stepper.sv
// ============================================================================
// Module      : mod_field_stepper
// Description : Combinational wrap-around increment/decrement of one field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_field_stepper #(
    parameter int LIMIT = 60
) (
    input  logic [5:0] value,
    input  logic       up,
    input  logic       down,
    output logic [5:0] next
);

    localparam logic [5:0] c_MAX = 6'(LIMIT - 1);

    always_comb begin
        next = value;
        if (up && !down) begin
            next = (value == c_MAX) ? 6'd0 : value + 6'd1;
        end else if (down && !up) begin
            next = (value == 6'd0) ? c_MAX : value - 6'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_set_controller.sv
// ============================================================================
// Module      : clock_set_controller
// Description : Button-driven time-setting sequencer: snapshot, edit h/m/s
//               fields with wrap, commit to the counter core with a load pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_set_controller
    import clock_set_controller_pkg::*;
#(
    parameter int L0_LIMIT     = DEF_L0_LIMIT,
    parameter int L1_LIMIT     = DEF_L1_LIMIT,
    parameter int L2_LIMIT     = DEF_L2_LIMIT,
    parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
    parameter int BLINK_HALF   = DEF_BLINK_HALF,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] l0_cur,
    input  logic [5:0] l1_cur,
    input  logic [5:0] l2_cur,
    output logic       enabled,
    output logic       load,
    output logic [5:0] l0_set,
    output logic [5:0] l1_set,
    output logic [5:0] l2_set,
    output logic       disp_sel,
    output logic [2:0] blink_mask
);

    localparam int c_LOAD_W  = $clog2(LOAD_CYCLES) + 1;
    localparam int c_BLINK_W = $clog2(BLINK_HALF) + 1;
    localparam int c_IDLE_W  = $clog2(IDLE_TIMEOUT) + 1;

    localparam logic [c_LOAD_W-1:0]  c_LOAD_LAST  = c_LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF - 1);
    localparam logic [c_IDLE_W-1:0]  c_IDLE_LAST  = c_IDLE_W'(IDLE_TIMEOUT - 1);

    set_state_t            r_state;
    set_state_t            w_state_next;
    logic [c_LOAD_W-1:0]   r_load_cnt;
    logic [c_BLINK_W-1:0]  r_blink_cnt;
    logic                  r_blink_off;
    logic [c_IDLE_W-1:0]   r_idle_cnt;
    logic [5:0]            r_l0_set;
    logic [5:0]            r_l1_set;
    logic [5:0]            r_l2_set;
    logic [5:0]            w_l0_next;
    logic [5:0]            w_l1_next;
    logic [5:0]            w_l2_next;
    logic                  w_in_edit;
    logic                  w_btn_any;
    logic                  w_timeout;

    assign w_in_edit = (r_state == EDIT_L2) || (r_state == EDIT_L1) || (r_state == EDIT_L0);
    assign w_btn_any = btn_mode || btn_up || btn_down;
    assign w_timeout = w_in_edit && !w_btn_any && (r_idle_cnt == c_IDLE_LAST);

    mod_field_stepper #(.LIMIT(L0_LIMIT)) u_step_l0 (
        .value (r_l0_set),
        .up    (btn_up),
        .down  (btn_down),
        .next  (w_l0_next)
    );

    mod_field_stepper #(.LIMIT(L1_LIMIT)) u_step_l1 (
        .value (r_l1_set),
        .up    (btn_up),
        .down  (btn_down),
        .next  (w_l1_next)
    );

    mod_field_stepper #(.LIMIT(L2_LIMIT)) u_step_l2 (
        .value (r_l2_set),
        .up    (btn_up),
        .down  (btn_down),
        .next  (w_l2_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        enabled      = 1'b1;
        load         = 1'b0;
        disp_sel     = 1'b0;
        blink_mask   = 3'b000;
        case (r_state)
            RUN: begin
                if (btn_mode) w_state_next = SNAP;
            end
            SNAP: begin
                w_state_next = EDIT_L2;
            end
            EDIT_L2: begin
                disp_sel         = 1'b1;
                blink_mask[F_L2] = r_blink_off;
                if (btn_mode)       w_state_next = EDIT_L1;
                else if (w_timeout) w_state_next = RUN;
            end
            EDIT_L1: begin
                disp_sel         = 1'b1;
                blink_mask[F_L1] = r_blink_off;
                if (btn_mode)       w_state_next = EDIT_L0;
                else if (w_timeout) w_state_next = RUN;
            end
            EDIT_L0: begin
                disp_sel         = 1'b1;
                blink_mask[F_L0] = r_blink_off;
                if (btn_mode)       w_state_next = COMMIT;
                else if (w_timeout) w_state_next = RUN;
            end
            COMMIT: begin
                disp_sel = 1'b1;
                load     = 1'b1;
                if (r_load_cnt == c_LOAD_LAST) w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Field registers: mode has priority over arithmetic in every edit state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_l0_set <= 6'd0;
            r_l1_set <= 6'd0;
            r_l2_set <= 6'd0;
        end else begin
            case (r_state)
                SNAP: begin
                    r_l0_set <= snap_field(l0_cur, L0_LIMIT);
                    r_l1_set <= snap_field(l1_cur, L1_LIMIT);
                    r_l2_set <= snap_field(l2_cur, L2_LIMIT);
                end
                EDIT_L2: if (!btn_mode) r_l2_set <= w_l2_next;
                EDIT_L1: if (!btn_mode) r_l1_set <= w_l1_next;
                EDIT_L0: if (!btn_mode) r_l0_set <= w_l0_next;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_load_cnt <= '0;
        end else if (r_state != COMMIT) begin
            r_load_cnt <= '0;
        end else begin
            r_load_cnt <= r_load_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (!w_in_edit || w_btn_any) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != c_IDLE_LAST) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Up/down restarts the on phase so the new value is shown at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (!w_in_edit || btn_up || btn_down) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_off <= !r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign l0_set = r_l0_set;
    assign l1_set = r_l1_set;
    assign l2_set = r_l2_set;

endmodule

`default_nettype wire

// File: tb/tb_clock_set_controller.sv
// ============================================================================
// Module      : tb_clock_set_controller
// Description : Scoreboard bench for clock_set_controller with short blink
//               half-period, 3-cycle load pulse and 100-cycle idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_set_controller;

    // Packed observation: {load, enabled, disp_sel, blink[2:0], l2, l1, l0}
    localparam logic [23:0] M_ALL   = 24'hFFFFFF;
    localparam logic [23:0] M_NOBL  = 24'hE3FFFF;
    localparam logic [23:0] M_LDSET = 24'h83FFFF;
    localparam logic [23:0] M_LDDS  = 24'hA00000;

    typedef struct {
        string       tag;
        logic [23:0] exp;
        logic [23:0] mask;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [5:0] l0_cur;
    logic [5:0] l1_cur;
    logic [5:0] l2_cur;
    logic       enabled;
    logic       load;
    logic [5:0] l0_set;
    logic [5:0] l1_set;
    logic [5:0] l2_set;
    logic       disp_sel;
    logic [2:0] blink_mask;
    logic [23:0] w_obs;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    clock_set_controller #(
        .L0_LIMIT     (60),
        .L1_LIMIT     (60),
        .L2_LIMIT     (24),
        .LOAD_CYCLES  (3),
        .BLINK_HALF   (4),
        .IDLE_TIMEOUT (100)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .l0_cur     (l0_cur),
        .l1_cur     (l1_cur),
        .l2_cur     (l2_cur),
        .enabled    (enabled),
        .load       (load),
        .l0_set     (l0_set),
        .l1_set     (l1_set),
        .l2_set     (l2_set),
        .disp_sel   (disp_sel),
        .blink_mask (blink_mask)
    );

    assign w_obs = {load, enabled, disp_sel, blink_mask, l2_set, l1_set, l0_set};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [23:0] pk(input logic ld, input logic en, input logic ds,
                                       input logic [2:0] bl, input logic [5:0] h,
                                       input logic [5:0] m, input logic [5:0] s);
        return {ld, en, ds, bl, h, m, s};
    endfunction

    task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [23:0] exp, input logic [23:0] mask);
        exp_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, w_obs & e.mask, e.exp & e.mask);
        end
    endtask

    // Drive one cycle of buttons, then compare what the DUT shows after the edge.
    task automatic cyc(input logic m, input logic u, input logic d, input string tag,
                       input logic [23:0] exp, input logic [23:0] mask);
        @(negedge clock);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        push_exp(tag, exp, mask);
        @(posedge clock);
        #1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        pop_check();
    endtask

    initial begin
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        l2_cur   = 6'd23;
        l1_cur   = 6'd59;
        l0_cur   = 6'd58;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        cyc(0, 0, 0, "reset",        pk(0, 1, 0, 3'b000, 0, 0, 0), M_ALL);

        // Snapshot and edit hours/minutes with wrap
        cyc(1, 0, 0, "enter",        pk(0, 1, 0, 3'b000, 0, 0, 0), M_LDSET);
        cyc(0, 0, 0, "snap",         pk(0, 1, 1, 3'b000, 23, 59, 58), M_ALL);
        cyc(0, 0, 0, "blink_on1",    pk(0, 1, 1, 3'b000, 23, 59, 58), M_ALL);
        cyc(0, 0, 0, "blink_on2",    pk(0, 1, 1, 3'b000, 23, 59, 58), M_ALL);
        cyc(0, 0, 0, "blink_on3",    pk(0, 1, 1, 3'b000, 23, 59, 58), M_ALL);
        cyc(0, 0, 0, "blink_off",    pk(0, 1, 1, 3'b100, 23, 59, 58), M_ALL);
        cyc(0, 1, 0, "l2_up_wrap",   pk(0, 1, 1, 3'b000, 0, 59, 58), M_ALL);
        cyc(0, 0, 1, "l2_down_wrap", pk(0, 1, 1, 3'b000, 23, 59, 58), M_ALL);
        cyc(0, 1, 1, "l2_updown",    pk(0, 1, 1, 3'b000, 23, 59, 58), M_ALL);
        cyc(1, 0, 0, "to_l1",        pk(0, 1, 1, 3'b000, 23, 59, 58), M_NOBL);
        cyc(0, 1, 0, "l1_up_wrap",   pk(0, 1, 1, 3'b000, 23, 0, 58), M_NOBL);
        cyc(0, 0, 1, "l1_down_wrap", pk(0, 1, 1, 3'b000, 23, 59, 58), M_NOBL);
        cyc(1, 1, 0, "mode_wins",    pk(0, 1, 1, 3'b000, 23, 59, 58), M_NOBL);
        cyc(0, 1, 0, "l0_up",        pk(0, 1, 1, 3'b000, 23, 59, 59), M_NOBL);
        cyc(0, 1, 0, "l0_up_wrap",   pk(0, 1, 1, 3'b000, 23, 59, 0), M_NOBL);

        // Idle timeout in EDIT_L0: 99 quiet cycles still editing, then RUN
        for (int i = 1; i < 100; i++) begin
            cyc(0, 0, 0, "idle_wait", pk(0, 1, 1, 3'b000, 23, 59, 0), M_LDDS);
        end
        cyc(0, 0, 0, "idle_timeout", pk(0, 1, 0, 3'b000, 23, 59, 0), M_ALL);

        // Commit with a 3-cycle load pulse
        l2_cur = 6'd12;
        l1_cur = 6'd34;
        l0_cur = 6'd56;
        cyc(1, 0, 0, "enter2",       pk(0, 1, 0, 3'b000, 23, 59, 0), M_LDSET);
        cyc(0, 0, 0, "snap2",        pk(0, 1, 1, 3'b000, 12, 34, 56), M_ALL);
        cyc(1, 0, 0, "c_to_l1",      pk(0, 1, 1, 3'b000, 12, 34, 56), M_NOBL);
        cyc(1, 0, 0, "c_to_l0",      pk(0, 1, 1, 3'b000, 12, 34, 56), M_NOBL);
        cyc(1, 0, 0, "commit_1",     pk(1, 1, 0, 3'b000, 12, 34, 56), M_LDSET);
        cyc(0, 1, 0, "commit_2",     pk(1, 1, 0, 3'b000, 12, 34, 56), M_LDSET);
        cyc(0, 0, 0, "commit_3",     pk(1, 1, 0, 3'b000, 12, 34, 56), M_LDSET);
        cyc(0, 0, 0, "commit_end",   pk(0, 1, 0, 3'b000, 12, 34, 56), M_ALL);

        // Out-of-range snapshot, buttons ignored in SNAP, reset mid-commit
        l2_cur = 6'd30;
        l1_cur = 6'd5;
        l0_cur = 6'd62;
        cyc(1, 0, 0, "enter3",       pk(0, 1, 0, 3'b000, 12, 34, 56), M_LDSET);
        cyc(0, 1, 0, "snap_clamp",   pk(0, 1, 1, 3'b000, 0, 5, 0), M_ALL);
        cyc(1, 0, 0, "r_to_l1",      pk(0, 1, 1, 3'b000, 0, 5, 0), M_NOBL);
        cyc(1, 0, 0, "r_to_l0",      pk(0, 1, 1, 3'b000, 0, 5, 0), M_NOBL);
        cyc(1, 0, 0, "r_commit_1",   pk(1, 1, 0, 3'b000, 0, 5, 0), M_LDSET);
        cyc(0, 0, 0, "r_commit_2",   pk(1, 1, 0, 3'b000, 0, 5, 0), M_LDSET);
        #1;
        reset_n = 1'b0;
        #1;
        push_exp("async_reset", pk(0, 1, 0, 3'b000, 0, 0, 0), M_ALL);
        pop_check();
        @(negedge clock);
        reset_n = 1'b1;
        cyc(0, 0, 0, "post_reset",   pk(0, 1, 0, 3'b000, 0, 0, 0), M_ALL);
        cyc(0, 0, 0, "post_reset2",  pk(0, 1, 0, 3'b000, 0, 0, 0), M_ALL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clock_set_controller.md
# clock_set_controller

Time-setting sequencer for the wall-clock counter core. It takes debounced button pulses, snapshots the running time, and walks the user through editing the hours (l2), minutes (l1) and seconds (l0) fields with wrap-around arithmetic. It then commits the edited values to the counter core with a load pulse of programmable length. It sits between the button front-end and the counter core and also drives the display blink mask.

## Interface
- L0_LIMIT, 60, modulus of field l0 (seconds)
- L1_LIMIT, 60, modulus of field l1 (minutes)
- L2_LIMIT, 24, modulus of field l2 (hours)
- LOAD_CYCLES, 1, length of the commit load pulse in clocks (≥1)
- BLINK_HALF, 250000, clocks per blink half-period
- IDLE_TIMEOUT, 10000000, clocks without any button press before edit is abandoned
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  one-cycle pulse: enter edit / advance field / commit
- btn_up  in  1  one-cycle pulse: increment selected field
- btn_down  in  1  one-cycle pulse: decrement selected field
- l0_cur, l1_cur, l2_cur  in  6 each  live counter-core outputs
- enabled  out  1  counter-core run enable
- load  out  1  counter-core modify request, high = load
- l0_set, l1_set, l2_set  out  6 each  values presented to the counter-core load inputs
- disp_sel  out  1  1 = display shows *_set, 0 = display shows *_cur
- blink_mask  out  3  bit i high = blank field li this phase

## Operation
- States: RUN, SNAP, EDIT_L2, EDIT_L1, EDIT_L0, COMMIT.
- RUN: enabled=1, load=0, disp_sel=0, blink_mask=0. On btn_mode, go to SNAP.
- SNAP: one cycle. Capture *_cur into *_set; any value ≥ its limit is captured as 0. Go to EDIT_L2.
- EDIT_Lx: enabled=1, disp_sel=1, load=0.
  - btn_up: set_x = (set_x == LIMIT_x−1) ? 0 : set_x+1.
  - btn_down: set_x = (set_x == 0) ? LIMIT_x−1 : set_x−1.
  - btn_mode: EDIT_L2→EDIT_L1→EDIT_L0→COMMIT.
- COMMIT: load=1 for exactly LOAD_CYCLES clocks with *_set held stable, then RUN.
- Simultaneous events:
  - btn_mode together with up/down: mode wins and the arithmetic is ignored.
  - btn_up and btn_down together: no change.
- Timeout: the idle counter resets on any button pulse. If it reaches IDLE_TIMEOUT−1 in any EDIT state, return to RUN without load; *_set is left unchanged.
- Buttons are ignored in SNAP and COMMIT.
- Blink: a free-running counter toggles the phase every BLINK_HALF clocks while in EDIT states. blink_mask has the bit for the current field set only during the off phase. Phase and counter restart at the off→on boundary on every up/down press, so the edited value is shown immediately.

## Timing
- Reset (async assert, sync release): state=RUN, *_set=0, enabled=1, load=0, disp_sel=0, blink_mask=0, all counters 0.
- btn_mode in RUN at edge N: SNAP during N+1, EDIT_L2 from N+2.
- up/down at edge N: the new set value is visible after edge N.
- btn_mode in EDIT_L0 at edge N: load high from N+1 to N+LOAD_CYCLES, low after that, and state is RUN.
- Reset mid-COMMIT drops load asynchronously; no partial load is extended.
- Width rules:
  - Field arithmetic is 6-bit, unsigned, with no overflow beyond the limit.
  - Counter widths are $clog2 of the respective parameter + 1.

## Structure
- Shared package holds:
  - the state enum (RUN, SNAP, EDIT_L2, EDIT_L1, EDIT_L0, COMMIT);
  - the field index constants (F_L0=0, F_L1=1, F_L2=2);
  - the default limits.
- One sub-module: mod_field_stepper. It is combinational and parameterised by LIMIT: inputs value, up, down; output next value with wrap. It is instantiated three times.
- The FSM, blink divider, idle timer and load-length counter live in the top level.

## Test plan
- Reset, then btn_mode with cur={l2=23, l1=59, l0=58} → SNAP, EDIT_L2, set={23,59,58}, disp_sel=1.
- EDIT_L2 at 23, btn_up → 0. Then btn_down → 23. In EDIT_L1 at 0, btn_down → 59.
- mode ×3 from edit with LOAD_CYCLES=3 and set={12,34,56} → load high for exactly 3 clocks with set={12,34,56}, then RUN, enabled=1.
- btn_up+btn_down in the same cycle → value unchanged. btn_mode+btn_up together in EDIT_L1 → advance to EDIT_L0 with l1 unchanged.
- IDLE_TIMEOUT=100, no presses in EDIT_L0 → RUN after 100 clocks, load never asserted.
- reset_n low during the second cycle of COMMIT → load=0 in the same cycle, state RUN, set=0. cur=62 captured in SNAP → set=0.
